// File: rtl/fetch_buffer.sv
// Instruction realignment buffer sitting right after the fetch stage.
// Word-aligned 32-bit fetch responses are queued as 16-bit halfwords, and
// one complete instruction (compressed or 32-bit) is presented per cycle,
// together with its pc, for decode. out_stall tells fetch to hold its
// address counter while too little room remains for another word.
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rdata,
    input  logic        in_ready,
    input  logic        in_align,
    input  logic        in_clear,
    input  logic        in_stall,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_done,
    output logic        out_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);
    localparam logic [AW:0] FOUR_C  = (AW+1)'(4);

    logic [15:0]   hw [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   head_pc;
    logic          first;

    logic [15:0]   h0;
    logic [15:0]   h1;
    logic          is_comp;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          single_push;
    logic [AW:0]   pop_n;
    logic [AW:0]   push_n;
    logic [AW:0]   free_after_pop;
    logic [AW:0]   count_next;

    // Head decode: the two oldest halfwords, wrapping naturally through the pointer width.
    assign h0      = hw[rd_ptr];
    assign h1      = hw[rd_ptr + AW'(1)];
    assign is_comp = (h0[1:0] != 2'b11);

    // A compressed head needs one stored halfword, a 32-bit head needs two.
    // Written so an empty buffer reports not-done regardless of stale storage.
    assign out_done  = (count >= TWO_C) || ((count == ONE_C) && is_comp);
    assign out_instr = !out_done ? 32'h0 :
                       (is_comp ? {16'h0, h0} : {h1, h0});
    assign out_pc    = head_pc;
    assign out_stall = (DEPTH_C - count) < FOUR_C;

    // Pop and push decisions. A redirect suppresses both.
    assign pop            = out_done && !in_stall && !in_clear;
    assign pop_n          = is_comp ? ONE_C : TWO_C;
    assign single_push    = first && in_align;
    assign push_n         = single_push ? ONE_C : TWO_C;
    assign push_req       = in_ready && !in_clear;
    assign free_after_pop = DEPTH_C - count + (pop ? pop_n : '0);
    assign push           = push_req && (free_after_pop >= TWO_C);
    assign count_next     = count + (push ? push_n : '0) - (pop ? pop_n : '0);

    // Halfword storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            if (single_push) begin
                hw[wr_ptr] <= in_rdata[31:16];
            end else begin
                hw[wr_ptr]          <= in_rdata[15:0];
                hw[wr_ptr + AW'(1)] <= in_rdata[31:16];
            end
        end
    end

    // Pointer, occupancy, head pc and first-push tracking; a redirect flushes
    // everything but leaves head_pc alone until the new stream arrives.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head_pc <= 32'h0;
            first   <= 1'b1;
        end else if (in_clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            first   <= 1'b1;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + pop_n[AW-1:0];
            end
            if (push) begin
                wr_ptr <= wr_ptr + push_n[AW-1:0];
            end
            count <= count_next;
            if (push && first) begin
                head_pc <= in_align ? (in_pc + 32'd2) : in_pc;
                first   <= 1'b0;
            end else if (pop) begin
                head_pc <= head_pc + (is_comp ? 32'd2 : 32'd4);
            end
        end
    end

    // A push that finds no room is dropped; legal fetch behaviour never gets here.
    always @(posedge clock) begin
        if (reset && push_req) begin
            assert (push);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a halfword-stream reference model
// produces expected instructions into a scoreboard queue, and a monitor on
// the falling clock edge compares and retires them as the DUT consumes them.
module tb_fetch_buffer;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_rdata = 32'h0;
    logic        in_ready = 1'b0;
    logic        in_align = 1'b0;
    logic        in_clear = 1'b0;
    logic        in_stall = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_done;
    logic        out_stall;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_pc     (in_pc),
        .in_rdata  (in_rdata),
        .in_ready  (in_ready),
        .in_align  (in_align),
        .in_clear  (in_clear),
        .in_stall  (in_stall),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_done  (out_done),
        .out_stall (out_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          len;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] pend[$];
    logic [31:0] pend_pc = 32'h0;
    bit          mfirst = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    // Halfwords currently held: complete instructions plus the pending tail.
    function automatic int mcount();
        int n;
        n = pend.size();
        foreach (expq[i]) n += expq[i].len;
        return n;
    endfunction

    function automatic void compare(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endfunction

    // Turn pending halfwords into complete instructions in stream order.
    function automatic void extract();
        bit          more;
        logic [15:0] h;
        more = 1'b1;
        while (more && pend.size() > 0) begin
            h = pend[0];
            if (h[1:0] != 2'b11) begin
                expq.push_back('{pend_pc, {16'h0, h}, 1});
                void'(pend.pop_front());
                pend_pc += 32'd2;
            end else if (pend.size() >= 2) begin
                expq.push_back('{pend_pc, {pend[1], h}, 2});
                void'(pend.pop_front());
                void'(pend.pop_front());
                pend_pc += 32'd4;
            end else begin
                more = 1'b0;
            end
        end
    endfunction

    // Reference model: absorbs pushes and redirects at each clock edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            expq.delete();
            pend.delete();
            pend_pc = 32'h0;
            mfirst  = 1'b1;
        end else if (in_clear) begin
            if (expq.size() > 0) pend_pc = expq[0].pc;
            expq.delete();
            pend.delete();
            mfirst = 1'b1;
        end else if (in_ready) begin
            if (mfirst) begin
                if (in_align) begin
                    pend.push_back(in_rdata[31:16]);
                    pend_pc = in_pc + 32'd2;
                end else begin
                    pend.push_back(in_rdata[15:0]);
                    pend.push_back(in_rdata[31:16]);
                    pend_pc = in_pc;
                end
                mfirst = 1'b0;
            end else begin
                pend.push_back(in_rdata[15:0]);
                pend.push_back(in_rdata[31:16]);
            end
            extract();
        end
    end

    // Monitor: compare the presented head against the scoreboard, then retire it if consumed.
    always @(negedge clock) begin
        int          n;
        bit          have;
        logic [31:0] want_pc;
        logic [31:0] want_instr;
        if (reset) begin
            n    = mcount();
            have = (expq.size() > 0);
            if (have) begin
                want_pc    = expq[0].pc;
                want_instr = expq[0].instr;
            end else begin
                want_pc    = pend_pc;
                want_instr = 32'h0;
            end
            compare("mon.out_stall", 32'(out_stall), 32'((DEPTH - n) < 4));
            compare("mon.out_done",  32'(out_done),  32'(have));
            compare("mon.out_pc",    out_pc,         want_pc);
            compare("mon.out_instr", out_instr,      want_instr);
            if (have && !in_stall && !in_clear) void'(expq.pop_front());
        end
    end

    task automatic applyStimulus(input logic rdy, input logic [31:0] data, input logic [31:0] pc,
                                 input logic aln, input logic clr, input logic stl);
        in_ready = rdy;
        in_rdata = data;
        in_pc    = pc;
        in_align = aln;
        in_clear = clr;
        in_stall = stl;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic done, input logic [31:0] pc,
                               input logic [31:0] instr, input logic stall);
        compare({name, ".done"},  32'(out_done),  32'(done));
        compare({name, ".pc"},    out_pc,         pc);
        compare({name, ".instr"}, out_instr,      instr);
        compare({name, ".stall"}, 32'(out_stall), 32'(stall));
    endtask

    task automatic pushWhenRoom(input logic [31:0] data, input logic [31:0] pc);
        int k;
        k = 0;
        while ((DEPTH - mcount()) < 4 && k < 16) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
            k++;
        end
        if (k >= 16) begin
            miscompares++;
            $display("[TB] FAIL room_wait: no space after %0d cycles, expected space", k);
        end
        applyStimulus(1'b1, data, pc, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && expq.size() > 0; k++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic        rdy;
        logic        clr;
        logic        stl;
        logic        aln;
        logic [31:0] data;
        logic [31:0] pc;

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 32'h0, 1'b0);

        // Two 32-bit instructions back to back.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b0, 1'b0);
        checkOutput("t1a", 1'b1, 32'h100, 32'h00A00093, 1'b0);
        applyStimulus(1'b1, 32'h00B00113, 32'h104, 1'b0, 1'b0, 1'b0);
        checkOutput("t1b", 1'b1, 32'h104, 32'h00B00113, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1c", 1'b0, 32'h108, 32'h0, 1'b0);

        // Two compressed instructions in one word.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h45014485, 32'h200, 1'b0, 1'b0, 1'b0);
        checkOutput("t2a", 1'b1, 32'h200, 32'h00004485, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2b", 1'b1, 32'h202, 32'h00004501, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2c", 1'b0, 32'h204, 32'h0, 1'b0);

        // Misaligned target: a 32-bit instruction straddles two fetched words.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h00934485, 32'h300, 1'b1, 1'b0, 1'b0);
        checkOutput("t3a", 1'b0, 32'h302, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h1234000A, 32'h304, 1'b0, 1'b0, 1'b0);
        checkOutput("t3b", 1'b1, 32'h302, 32'h000A0093, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3c", 1'b1, 32'h306, 32'h00001234, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3d", 1'b0, 32'h308, 32'h0, 1'b0);

        // Fill under downstream stall, then drain across the pointer wrap.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h00A00093, 32'h400, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h45014485, 32'h404, 1'b0, 1'b0, 1'b1);
        checkOutput("t4a", 1'b1, 32'h400, 32'h00A00093, 1'b0);
        applyStimulus(1'b1, 32'h00B00113, 32'h408, 1'b0, 1'b0, 1'b1);
        checkOutput("t4b", 1'b1, 32'h400, 32'h00A00093, 1'b1);
        pushWhenRoom(32'h00C00193, 32'h40C);
        pushWhenRoom(32'h45054489, 32'h410);
        pushWhenRoom(32'h00D00213, 32'h414);
        pushWhenRoom(32'h45094491, 32'h418);
        drain();

        // Redirect in the same cycle as a stale push.
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h999C, 1'b0, 1'b1, 1'b0);
        checkOutput("t5a", 1'b0, pend_pc, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h00000001, 32'h500, 1'b0, 1'b0, 1'b0);
        checkOutput("t5b", 1'b1, 32'h500, 32'h00000001, 1'b0);
        drain();

        // Asynchronous reset mid-stream with five halfwords held.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h00010001, 32'h600, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00010001, 32'h604, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00010001, 32'h608, 1'b0, 1'b0, 1'b1);
        compare("t6.count", 32'(mcount()), 32'd5);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6rst", 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
        applyStimulus(1'b1, 32'h00A00093, 32'h700, 1'b0, 1'b0, 1'b0);
        checkOutput("t6b", 1'b1, 32'h700, 32'h00A00093, 1'b0);
        drain();

        // Randomized traffic: pushes only when the model shows room for another word.
        for (int i = 0; i < 1500; i++) begin
            clr  = ($urandom_range(0, 49) == 0);
            stl  = ($urandom_range(0, 3) == 0);
            rdy  = ($urandom_range(0, 3) != 0) && ((DEPTH - mcount()) >= 4);
            aln  = 1'($urandom_range(0, 1));
            data = $urandom();
            pc   = $urandom() & 32'hFFFF_FFFC;
            applyStimulus(rdy, data, pc, aln, clr, stl);
        end
        drain();
        compare("drain.remaining", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
